// File: rtl/spi_slave_multi.sv
// SPI slave that assembles WORD_WIDTH-bit words from FRAME_BITS-bit frames separated by ss pulses.
// Supports all four SPI modes, a TX holding register, handshaked RX, and error pulses.
module spi_slave_multi #(
    parameter int WORD_WIDTH    = 16,
    parameter int FRAME_BITS    = 8,
    parameter int PAUSE_TIMEOUT = 0,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic                  spi_ss,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  frame_err
);
    localparam int NFRAMES = WORD_WIDTH / FRAME_BITS;
    localparam int BW      = $clog2(FRAME_BITS + 1);
    localparam int FW      = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam int PW      = (PAUSE_TIMEOUT > 0) ? $clog2(PAUSE_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, PAUSE, DONE} state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_ss_sync, r_sclk_sync, r_mosi_sync;
    logic                    r_sclk_d;
    logic                    r_cpol, r_cpha, r_first_lead;
    logic [BW-1:0]           r_bit_cnt;
    logic [FW-1:0]           r_frame_cnt;
    logic [PW-1:0]           r_pause_cnt;
    logic [WORD_WIDTH-1:0]   r_rx_shift, r_tx_shift, r_hold, r_rx_data;
    logic                    r_hold_full, r_rx_valid, r_miso;
    logic                    r_frame_err, r_rx_overrun, r_tx_underrun;

    logic w_ss, w_sclk, w_mosi, w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;

    assign w_ss     = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk   = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk & ~r_sclk_d;
    assign w_fall   = ~w_sclk & r_sclk_d;
    assign w_lead   = r_cpol ? w_fall : w_rise;
    assign w_trail  = r_cpol ? w_rise : w_fall;
    assign w_sample = r_cpha ? w_trail : w_lead;
    assign w_shift  = r_cpha ? w_lead : w_trail;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_state       <= IDLE;
            r_sclk_d      <= 1'b0;
            r_cpol        <= 1'b0;
            r_cpha        <= 1'b0;
            r_first_lead  <= 1'b0;
            r_bit_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_pause_cnt   <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_miso        <= 1'b0;
            r_frame_err   <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_frame_err   <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_sclk_d      <= w_sclk;
            r_miso        <= ~w_ss & r_tx_shift[WORD_WIDTH-1];

            if (r_rx_valid && rx_ready)
                r_rx_valid <= 1'b0;
            // A write landing on the word-start cycle stays in holding for the next word.
            if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (!w_ss) begin
                        r_state      <= SHIFT;
                        r_cpol       <= cfg_cpol;
                        r_cpha       <= cfg_cpha;
                        r_first_lead <= 1'b1;
                        if (r_hold_full) begin
                            r_tx_shift  <= r_hold;
                            r_hold_full <= 1'b0;
                        end else begin
                            r_tx_shift    <= '0;
                            r_tx_underrun <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (w_ss) begin
                        if (r_bit_cnt != BW'(FRAME_BITS)) begin
                            r_frame_err <= 1'b1;
                            r_bit_cnt   <= '0;
                            r_frame_cnt <= '0;
                            r_rx_shift  <= '0;
                            r_state     <= IDLE;
                        end else if (r_frame_cnt == FW'(NFRAMES - 1)) begin
                            r_state <= DONE;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FW'(1);
                            r_bit_cnt   <= '0;
                            r_pause_cnt <= '0;
                            r_state     <= PAUSE;
                        end
                    end else begin
                        if (w_sample && (r_bit_cnt < BW'(FRAME_BITS))) begin
                            r_rx_shift <= {r_rx_shift[WORD_WIDTH-2:0], w_mosi};
                            r_bit_cnt  <= r_bit_cnt + BW'(1);
                        end
                        // In CPHA=1 the first leading edge only marks the start; bit 0 is already out.
                        if (w_shift && !(r_cpha && r_first_lead))
                            r_tx_shift <= {r_tx_shift[WORD_WIDTH-2:0], 1'b0};
                        if (w_lead)
                            r_first_lead <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (!w_ss) begin
                        r_state <= SHIFT;
                    end else if (PAUSE_TIMEOUT > 0 && r_pause_cnt == PW'(PAUSE_TIMEOUT)) begin
                        r_frame_err <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_frame_cnt <= '0;
                        r_rx_shift  <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_pause_cnt <= r_pause_cnt + PW'(1);
                    end
                end
                DONE: begin
                    if (!r_rx_valid || rx_ready) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_rx_overrun <= 1'b1;
                    end
                    r_bit_cnt   <= '0;
                    r_frame_cnt <= '0;
                    r_rx_shift  <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi_miso    = r_miso;
    assign tx_ready    = ~r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;
endmodule

// File: tb/tb_spi_slave_multi.sv
// Bench for spi_slave_multi: a 16-bit instance (pause timeout 50) and a 32-bit instance,
// driven by a bit-level SPI master and checked against a word-level model.
module tb_spi_slave_multi;
    localparam int H = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_b, cfg_cpol, cfg_cpha, sclk, mosi, ss_a, ss_b;
    logic [31:0] tx_data;
    logic        tx_valid_a, tx_valid_b, rx_ready_a, rx_ready_b;
    logic        miso_a, tx_ready_a, rx_valid_a, ovr_a, und_a, fe_a;
    logic        miso_b, tx_ready_b, rx_valid_b, ovr_b, und_b, fe_b;
    logic [15:0] rx_data_a;
    logic [31:0] rx_data_b;

    spi_slave_multi #(.WORD_WIDTH(16), .FRAME_BITS(8), .PAUSE_TIMEOUT(50), .SYNC_STAGES(2)) u_a (
        .clk(clk), .reset_b(reset_b), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .spi_ss(ss_a), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso_a),
        .tx_data(tx_data[15:0]), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
        .rx_overrun(ovr_a), .tx_underrun(und_a), .frame_err(fe_a));

    spi_slave_multi #(.WORD_WIDTH(32), .FRAME_BITS(8), .PAUSE_TIMEOUT(0), .SYNC_STAGES(2)) u_b (
        .clk(clk), .reset_b(reset_b), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .spi_ss(ss_b), .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso_b),
        .tx_data(tx_data), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
        .rx_overrun(ovr_b), .tx_underrun(und_b), .frame_err(fe_b));

    int vectors = 0, miscompares = 0;
    int cycles = 0, t_fe_a = 0;
    int fe_cnt [2];
    int ovr_cnt [2];
    int und_cnt [2];
    int exp_und [2];
    logic        hold_full [2];
    logic [31:0] hold_val [2];

    always @(posedge clk) cycles++;

    initial begin
        for (int i = 0; i < 2; i++) begin
            fe_cnt[i] = 0; ovr_cnt[i] = 0; und_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (fe_a) begin fe_cnt[0]++; t_fe_a = cycles; end
        if (fe_b) fe_cnt[1]++;
        if (ovr_a) ovr_cnt[0]++;
        if (ovr_b) ovr_cnt[1]++;
        if (und_a) und_cnt[0]++;
        if (und_b) und_cnt[1]++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_miso(input int sel);
        return (sel == 0) ? miso_a : miso_b;
    endfunction

    function automatic logic [31:0] get_rx(input int sel);
        return (sel == 0) ? {16'h0, rx_data_a} : rx_data_b;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? rx_valid_a : rx_valid_b;
    endfunction

    task automatic set_ss(input int sel, input logic v);
        if (sel == 0) ss_a = v; else ss_b = v;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        cfg_cpol = pol; cfg_cpha = pha; sclk = pol;
        cyc(4);
    endtask

    task automatic write_tx(input int sel, input logic [31:0] d);
        tx_data = d;
        if (sel == 0) tx_valid_a = 1'b1; else tx_valid_b = 1'b1;
        cyc(1);
        tx_valid_a = 1'b0; tx_valid_b = 1'b0;
        if (!hold_full[sel]) begin hold_full[sel] = 1'b1; hold_val[sel] = d; end
    endtask

    // Word start: the holding word goes out on MISO, or zeros plus an underrun if empty.
    task automatic start_model(input int sel, output logic [31:0] exp_m);
        exp_m = hold_full[sel] ? hold_val[sel] : 32'h0;
        if (!hold_full[sel]) exp_und[sel]++;
        hold_full[sel] = 1'b0;
    endtask

    task automatic xfer(input int sel, input logic [31:0] word, input int width,
                        input int last_bits, input int pause, output logic [31:0] mw);
        int nf, nb, idx;
        nf = width / 8;
        mw = 32'h0;
        for (int f = 0; f < nf; f++) begin
            nb = (f == nf - 1) ? last_bits : 8;
            set_ss(sel, 1'b0);
            cyc(H);
            for (int b = 0; b < nb; b++) begin
                idx = width - 1 - (f * 8 + b);
                if (!cfg_cpha) begin
                    mosi = word[idx];
                    cyc(H);
                    mw = {mw[30:0], get_miso(sel)};
                    sclk = ~sclk;
                    cyc(H);
                    sclk = ~sclk;
                end else begin
                    sclk = ~sclk;
                    mosi = word[idx];
                    cyc(H);
                    mw = {mw[30:0], get_miso(sel)};
                    sclk = ~sclk;
                    cyc(H);
                end
            end
            cyc(H);
            set_ss(sel, 1'b1);
            if (f < nf - 1) cyc(pause);
        end
    endtask

    task automatic wait_rx(input int sel);
        for (int i = 0; i < 40; i++) begin
            if (get_valid(sel)) break;
            cyc(1);
        end
        chk("rx_valid_set", 32'(get_valid(sel)), 32'd1);
    endtask

    task automatic accept(input int sel);
        if (sel == 0) rx_ready_a = 1'b1; else rx_ready_b = 1'b1;
        cyc(1);
        rx_ready_a = 1'b0; rx_ready_b = 1'b0;
        chk("rx_valid_clr", 32'(get_valid(sel)), 32'd0);
    endtask

    task automatic word_check(input int sel, input logic [31:0] word, input int pause);
        logic [31:0] exp_m, mw, mask;
        int width;
        width = (sel == 0) ? 16 : 32;
        mask  = (sel == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        start_model(sel, exp_m);
        xfer(sel, word, width, 8, pause, mw);
        wait_rx(sel);
        $display("word dut=%0d mode=%0d%0d sent=%h rx=%h miso=%h exp_miso=%h",
                 sel, cfg_cpol, cfg_cpha, word & mask, get_rx(sel), mw, exp_m & mask);
        chk("rx_data", get_rx(sel), word & mask);
        chk("miso_word", mw, exp_m & mask);
        chk("underruns", 32'(und_cnt[sel]), 32'(exp_und[sel]));
        accept(sel);
    endtask

    initial begin
        logic [31:0] mw, em;
        int fe0, ovr0, t0;
        for (int i = 0; i < 2; i++) begin
            hold_full[i] = 1'b0; hold_val[i] = 32'h0; exp_und[i] = 0;
        end
        reset_b = 1'b0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; sclk = 1'b0; mosi = 1'b0;
        ss_a = 1'b1; ss_b = 1'b1; tx_data = 32'h0;
        tx_valid_a = 1'b0; tx_valid_b = 1'b0; rx_ready_a = 1'b0; rx_ready_b = 1'b0;
        cyc(3);
        chk("rst_rx_valid_a", 32'(rx_valid_a), 32'd0);
        chk("rst_rx_data_a", get_rx(0), 32'd0);
        chk("rst_miso_a", 32'(miso_a), 32'd0);
        chk("rst_tx_ready_a", 32'(tx_ready_a), 32'd1);
        chk("rst_pulses_a", 32'({fe_a, ovr_a, und_a}), 32'd0);
        chk("rst_rx_valid_b", 32'(rx_valid_b), 32'd0);
        chk("rst_tx_ready_b", 32'(tx_ready_b), 32'd1);
        reset_b = 1'b1;
        cyc(3);

        // Mode 0 directed word, then randomized modes and data on the 16-bit instance.
        set_mode(1'b0, 1'b0);
        write_tx(0, 32'h0000_A55A);
        chk("tx_ready_full", 32'(tx_ready_a), 32'd0);
        word_check(0, 32'h0000_1234, 20);
        chk("tx_ready_empty", 32'(tx_ready_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            write_tx(0, $urandom);
            word_check(0, $urandom, int'($urandom_range(10, 30)));
        end

        // 32-bit instance in all four modes.
        for (int m = 0; m < 4; m++) begin
            set_mode(1'(m >> 1), 1'(m & 1));
            write_tx(1, $urandom);
            word_check(1, 32'hDEAD_BEEF, int'($urandom_range(10, 30)));
        end

        // Short second frame: one frame error, no word delivered.
        set_mode(1'b0, 1'b0);
        write_tx(0, $urandom);
        fe0 = fe_cnt[0];
        start_model(0, em);
        xfer(0, 32'h0000_5A5A, 16, 5, 20, mw);
        cyc(12);
        chk("frame_err_count", 32'(fe_cnt[0] - fe0), 32'd1);
        chk("frame_err_no_rx", 32'(rx_valid_a), 32'd0);
        write_tx(0, $urandom);
        word_check(0, 32'h0000_00FF, 20);

        // Stall after the first frame until the pause timeout aborts the word.
        write_tx(0, $urandom);
        fe0 = fe_cnt[0];
        start_model(0, em);
        xfer(0, 32'h0000_0077, 8, 8, 0, mw);
        t0 = cycles;
        for (int i = 0; i < 80; i++) begin
            if (fe_cnt[0] != fe0) break;
            cyc(1);
        end
        cyc(2);
        chk("timeout_err", 32'(fe_cnt[0] - fe0), 32'd1);
        chk("timeout_latency", 32'((t_fe_a - t0) >= 48 && (t_fe_a - t0) <= 58), 32'd1);
        chk("timeout_no_rx", 32'(rx_valid_a), 32'd0);
        write_tx(0, $urandom);
        word_check(0, $urandom, 15);

        // Overrun: second word arrives while the first is still unaccepted.
        write_tx(0, $urandom);
        start_model(0, em);
        xfer(0, 32'h0000_1111, 16, 8, 20, mw);
        wait_rx(0);
        chk("ovr_first_word", get_rx(0), 32'h0000_1111);
        ovr0 = ovr_cnt[0];
        write_tx(0, $urandom);
        start_model(0, em);
        xfer(0, 32'h0000_2222, 16, 8, 20, mw);
        cyc(12);
        chk("ovr_count", 32'(ovr_cnt[0] - ovr0), 32'd1);
        chk("ovr_data_kept", get_rx(0), 32'h0000_1111);
        chk("ovr_miso", mw, em & 32'hFFFF);
        accept(0);

        // No TX word supplied: underrun and an all-zero MISO word.
        word_check(0, $urandom, 20);

        // Reset in the middle of a frame with a pending RX word and a full holding register.
        write_tx(0, $urandom);
        start_model(0, em);
        xfer(0, 32'h0000_3C3C, 16, 8, 20, mw);
        wait_rx(0);
        write_tx(0, 32'h0000_FFFF);
        start_model(0, em);
        fe0 = fe_cnt[0];
        ss_a = 1'b0;
        cyc(H);
        mosi = 1'b1; sclk = 1'b1; cyc(H); sclk = 1'b0; cyc(H);
        write_tx(0, 32'h0000_8001);
        chk("pre_rst_tx_ready", 32'(tx_ready_a), 32'd0);
        reset_b = 1'b0;
        cyc(1);
        hold_full[0] = 1'b0;
        chk("mid_rst_rx_valid", 32'(rx_valid_a), 32'd0);
        chk("mid_rst_rx_data", get_rx(0), 32'd0);
        chk("mid_rst_miso", 32'(miso_a), 32'd0);
        chk("mid_rst_tx_ready", 32'(tx_ready_a), 32'd1);
        ss_a = 1'b1;
        cyc(3);
        reset_b = 1'b1;
        cyc(6);
        chk("mid_rst_no_err", 32'(fe_cnt[0] - fe0), 32'd0);
        word_check(0, $urandom, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
